// File: rtl/keypad_pkg.sv
// Definitions shared by the keypad encoder and the entry sequencer:
// key codes and the sequencer state encoding.
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_CLEAR     = 4'd10;
  localparam logic [3:0] KEY_BKSP      = 4'd11;
  localparam logic [3:0] KEY_ENTER     = 4'd13;
  localparam logic [3:0] KEY_NONE      = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the {pressed, code} bundle.
// Both flop stages clear to zero on reset.
module key_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d,
  output logic [4:0] q
);

  logic [4:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Turns keypad presses into one edit action each, builds a BCD entry and
// hands completed numbers downstream over valid/ready.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          key_code,
  input  logic                key_pressed,
  input  logic                entry_ready,
  output logic                entry_valid,
  output logic [4*DIGITS-1:0] entry_value,
  output logic [4*DIGITS-1:0] disp_digits,
  output logic [3:0]          digit_count,
  output logic                key_err,
  output logic                busy
);

  // state   | meaning
  // IDLE    | waiting for a press; acts once on it
  // RELEASE | press consumed, waiting for the key to come up
  // OUT     | committed entry held until the consumer takes it
  localparam int         W       = 4 * DIGITS;
  localparam logic [3:0] MAX_CNT = 4'(DIGITS);

  logic [4:0]   sync_q;
  logic         pressed_s;
  logic [3:0]   code_s;
  state_t       state, state_n;
  logic [W-1:0] buffer, buffer_n, value_n;
  logic [3:0]   count, count_n;
  logic         err_n;

  key_sync u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   ({key_pressed, key_code}),
    .q   (sync_q)
  );

  assign {pressed_s, code_s} = sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      buffer      <= '0;
      count       <= '0;
      entry_value <= '0;
      key_err     <= 1'b0;
    end else begin
      state       <= state_n;
      buffer      <= buffer_n;
      count       <= count_n;
      entry_value <= value_n;
      key_err     <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    count_n  = count;
    value_n  = entry_value;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pressed_s) begin
          state_n = ST_RELEASE;
          if (code_s <= KEY_DIGIT_MAX) begin
            // Newest digit enters at the least significant nibble.
            if (count < MAX_CNT) begin
              buffer_n = (buffer << 4) | W'(code_s);
              count_n  = count + 4'd1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            case (code_s)
              KEY_CLEAR: begin
                buffer_n = '0;
                count_n  = '0;
              end
              KEY_BKSP: begin
                if (count != 4'd0) begin
                  buffer_n = buffer >> 4;
                  count_n  = count - 4'd1;
                end else begin
                  err_n = 1'b1;
                end
              end
              KEY_ENTER: begin
                if (count != 4'd0) begin
                  value_n  = buffer;
                  buffer_n = '0;
                  count_n  = '0;
                  state_n  = ST_OUT;
                end else begin
                  err_n = 1'b1;
                end
              end
              default: err_n = 1'b1;
            endcase
          end
        end
      end
      ST_RELEASE: begin
        if (!pressed_s) state_n = ST_IDLE;
      end
      ST_OUT: begin
        if (entry_ready) state_n = ST_RELEASE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign entry_valid = (state == ST_OUT);
  assign busy        = (state == ST_OUT);
  assign disp_digits = buffer;
  assign digit_count = count;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized and directed bench for keypad_entry_ctrl against a digit-queue
// model of the entry buffer.
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = KEY_NONE;
  logic        key_pressed = 1'b0;
  logic        entry_ready = 1'b1;
  logic        entry_valid;
  logic [15:0] entry_value;
  logic [15:0] disp_digits;
  logic [3:0]  digit_count;
  logic        key_err;
  logic        busy;

  keypad_entry_ctrl #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .entry_ready (entry_ready),
    .entry_valid (entry_valid),
    .entry_value (entry_value),
    .disp_digits (disp_digits),
    .digit_count (digit_count),
    .key_err     (key_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: digits as a queue, oldest first.
  int          mq[$];
  logic [15:0] exp_q[$];
  int          exp_err = 0;

  function automatic logic [15:0] mval();
    logic [15:0] v = '0;
    foreach (mq[i]) v = (v << 4) | 16'(mq[i]);
    return v;
  endfunction

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (mq.size() < DIGITS) mq.push_back(k);
      else exp_err++;
    end else if (k == 10) begin
      mq.delete();
    end else if (k == 11) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else exp_err++;
    end else if (k == 13) begin
      if (mq.size() > 0) begin
        exp_q.push_back(mval());
        mq.delete();
      end else exp_err++;
    end else begin
      exp_err++;
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [15:0] got_q[$];
  int   err_pulses = 0;
  int   err_cycles = 0;
  int   valid_cycles = 0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (key_err) err_cycles++;
    if (key_err && !err_prev) err_pulses++;
    err_prev = key_err;
    if (entry_valid) valid_cycles++;
    if (entry_valid && entry_ready) got_q.push_back(entry_value);
  end

  task automatic press(input int k, input int hold, input int rel);
    key_code    = 4'(k);
    key_pressed = 1'b1;
    repeat (hold) @(posedge clk);
    #1 key_pressed = 1'b0;
    repeat (rel) @(posedge clk);
    #1;
  endtask

  task automatic press_m(input int k, input int hold, input int rel);
    press(k, hold, rel);
    model_key(k);
  endtask

  task automatic chk_buf(input string tag);
    chk({tag, "_disp"}, 32'(disp_digits), 32'(mval()));
    chk({tag, "_count"}, 32'(digit_count), 32'(mq.size()));
  endtask

  initial begin
    int e0, v0, k;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", 32'(entry_valid), 0);
    chk("rst_value", 32'(entry_value), 0);
    chk("rst_disp",  32'(disp_digits), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_err",   32'(key_err), 0);
    chk("rst_busy",  32'(busy), 0);

    // 1,2,3 then Enter with ready high
    v0 = valid_cycles;
    press_m(1, 10, 10);
    press_m(2, 10, 10);
    press_m(3, 10, 10);
    chk_buf("d123");
    press_m(13, 10, 10);
    chk("enter_valid_width", valid_cycles - v0, 1);
    chk("enter_disp", 32'(disp_digits), 0);
    chk("enter_busy", 32'(busy), 0);

    // Long hold does not repeat
    press_m(7, 200, 10);
    chk("hold_disp", 32'(disp_digits), 32'h0007);
    chk("hold_count", 32'(digit_count), 1);
    press_m(10, 5, 6);

    // Overflow, backspace, clear
    press_m(9, 4, 6); press_m(8, 4, 6); press_m(7, 4, 6); press_m(6, 4, 6);
    e0 = err_pulses;
    press_m(5, 4, 6);
    chk("ovf_err", err_pulses - e0, 1);
    chk("ovf_disp", 32'(disp_digits), 32'h9876);
    chk("ovf_count", 32'(digit_count), 4);
    press_m(11, 4, 6);
    chk("bksp_disp", 32'(disp_digits), 32'h0987);
    chk("bksp_count", 32'(digit_count), 3);
    press_m(10, 4, 6);
    chk_buf("clear");

    // Enter and backspace on an empty buffer
    e0 = err_pulses; v0 = valid_cycles;
    press_m(13, 4, 6);
    chk("enter_empty_err", err_pulses - e0, 1);
    chk("enter_empty_valid", valid_cycles - v0, 0);
    press_m(11, 4, 6);
    chk("bksp_empty_err", err_pulses - e0, 2);
    chk("bksp_empty_count", 32'(digit_count), 0);

    // Held entry with ready low; presses during OUT are ignored
    entry_ready = 1'b0;
    press_m(5, 4, 6);
    press_m(13, 4, 6);
    chk("out_valid", 32'(entry_valid), 1);
    chk("out_busy", 32'(busy), 1);
    chk("out_value", 32'(entry_value), 32'h0005);
    press(4, 5, 10);
    chk("out_hold_valid", 32'(entry_valid), 1);
    chk("out_hold_value", 32'(entry_value), 32'h0005);
    chk("out_hold_disp", 32'(disp_digits), 0);
    chk("out_hold_count", 32'(digit_count), 0);
    entry_ready = 1'b1;
    @(posedge clk); #1;
    chk("xfer_valid", 32'(entry_valid), 0);
    chk("xfer_busy", 32'(busy), 0);
    press_m(2, 4, 6);
    chk_buf("after_xfer");
    press_m(10, 4, 6);

    // Reset while in OUT with a key held: no entry emitted
    entry_ready = 1'b0;
    press(3, 4, 6);
    press(13, 4, 6);
    chk("pre_rst_valid", 32'(entry_valid), 1);
    key_code = 4'd8; key_pressed = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(entry_valid), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_value", 32'(entry_value), 0);
    chk("arst_disp",  32'(disp_digits), 0);
    chk("arst_count", 32'(digit_count), 0);
    mq.delete();
    key_pressed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; entry_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk_buf("post_rst");
    press_m(6, 4, 6);
    chk_buf("post_rst_press");

    // Randomized presses against the model
    for (int i = 0; i < 60; i++) begin
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      press_m(k, $urandom_range(1, 15), $urandom_range(4, 8));
      chk_buf($sformatf("rnd%0d_k%0d", i, k));
    end
    repeat (4) @(posedge clk); #1;

    chk("err_pulses", err_pulses, exp_err);
    chk("err_width", err_cycles, err_pulses);
    chk("entries_n", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("entry%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
